// File: rtl/ps2_kbd_tx_pkg.sv
// ps2_pkg: shared definitions for the PS/2 keyboard device model.
//   ps2_state_e    : serialiser engine states (IDLE, HIGH, LOW, GAP)
//   PS2_FRAME_BITS : bits per device-to-host frame (start, 8 data, parity, stop)
//   PS2_LAST_BIT   : index of the stop bit within a frame
//   odd_parity()   : parity bit that makes the nine data+parity bits odd
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_GAP  = 2'd3
  } ps2_state_e;

  localparam int         PS2_FRAME_BITS = 11;
  localparam logic [3:0] PS2_LAST_BIT   = 4'(PS2_FRAME_BITS - 1);

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_kbd_tx_fifo.sv
// ps2_tx_fifo: synchronous DEPTH x 8 scan-code FIFO.
//   clock, reset (sync, active-low) : clock and flush
//   push, wdata                     : write side (ignored while full)
//   pop, rdata                      : read side, rdata shows the head entry
//   full, empty                     : occupancy flags
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module ps2_tx_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic        do_push_s;
  logic        do_pop_s;

  assign empty     = (wptr_q == rptr_q);
  assign full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rdata     = mem_q[rptr_q[AW-1:0]];
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;

  // Next-state pointers; a simultaneous push and pop both advance.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push_s) begin
      wptr_d = wptr_q + PTR_ONE;
    end else begin
      wptr_d = wptr_q;
    end
    if (do_pop_s) begin
      rptr_d = rptr_q + PTR_ONE;
    end else begin
      rptr_d = rptr_q;
    end
  end

  // Pointer registers, flushed by reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clock) begin
    if (do_push_s) begin
      mem_q[wptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/ps2_kbd_tx.sv
// ps2_kbd_tx: PS/2 keyboard device model. Buffers scan codes and sends each
// one as an 11-bit device-to-host frame on ps2_clk/ps2_data.
//   clock, reset (sync, active-low)
//   in_valid, in_data, in_ready : byte input handshake (in_ready = FIFO not full)
//   ps2_clk, ps2_data           : registered PS/2 line outputs, idle high
//   busy                        : frame in progress or bytes still queued
// Line outputs are a registered decode of the engine state, so they lag the
// state by one clock; every timing figure below is seen at the pins.
module ps2_kbd_tx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV    = 8,
  parameter int GAP        = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy
);

  localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_RELOAD = 8'(GAP - 1);

  ps2_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic [8:0]  shreg_q, shreg_d;
  logic        ps2_clk_q, ps2_clk_d;
  logic        ps2_data_q, ps2_data_d;
  logic        busy_q, busy_hold_q;
  logic        busy_s;
  logic        cur_bit_s;
  logic        pop_s;
  logic        fifo_full_s, fifo_empty_s;
  logic [7:0]  fifo_rdata_s;

  ps2_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (in_valid),
    .wdata (in_data),
    .pop   (pop_s),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign in_ready = ~fifo_full_s;
  assign ps2_clk  = ps2_clk_q;
  assign ps2_data = ps2_data_q;
  assign busy     = busy_q;

  // Bit on the line for the current index: start, then data/parity from the
  // shift register's LSB, then stop.
  always_comb begin
    if (idx_q == 4'd0) begin
      cur_bit_s = 1'b0;
    end else if (idx_q == PS2_LAST_BIT) begin
      cur_bit_s = 1'b1;
    end else begin
      cur_bit_s = shreg_q[0];
    end
  end

  // Serialiser FSM and half-period / gap divider.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    pop_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          shreg_d = {odd_parity(fifo_rdata_s), fifo_rdata_s};
          idx_d   = 4'd0;
          cnt_d   = DIV_RELOAD;
          state_d = ST_HIGH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HIGH: begin
        if (cnt_q == 8'd0) begin
          cnt_d   = DIV_RELOAD;
          state_d = ST_LOW;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_LOW: begin
        if (cnt_q == 8'd0) begin
          if (idx_q < PS2_LAST_BIT) begin
            idx_d   = idx_q + 4'd1;
            cnt_d   = DIV_RELOAD;
            state_d = ST_HIGH;
            // The start bit is not held in the shift register, so shifting
            // begins only once a data bit has been sent.
            if (idx_q != 4'd0) begin
              shreg_d = {1'b0, shreg_q[8:1]};
            end else begin
              shreg_d = shreg_q;
            end
          end else begin
            cnt_d   = GAP_RELOAD;
            state_d = ST_GAP;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Line decode: data is held through LOW so the stop bit is still valid on
  // the receiver's final falling-edge sample.
  always_comb begin
    ps2_clk_d = (state_q != ST_LOW);
    if ((state_q == ST_HIGH) || (state_q == ST_LOW)) begin
      ps2_data_d = cur_bit_s;
    end else begin
      ps2_data_d = 1'b1;
    end
    busy_s = (state_q != ST_IDLE) || !fifo_empty_s;
  end

  // State and output registers. busy is stretched by one extra clock so it
  // also covers the idle-high cycle in which the engine looks for a new byte,
  // matching the pin-level lag of the line outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      idx_q       <= 4'd0;
      shreg_q     <= 9'd0;
      ps2_clk_q   <= 1'b1;
      ps2_data_q  <= 1'b1;
      busy_q      <= 1'b0;
      busy_hold_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      ps2_clk_q   <= ps2_clk_d;
      ps2_data_q  <= ps2_data_d;
      busy_q      <= busy_s | busy_hold_q;
      busy_hold_q <= busy_s;
    end
  end

endmodule
